// File: rtl/logic_gate_pipe.sv
// Selectable bitwise logic over N_CH channels, carried through an elastic STAGES-deep pipeline.
// Latency STAGES cycles; in_ready drops only when every slot is full and the tail is stalled.
module logic_gate_pipe #(
    parameter int WIDTH  = 8,
    parameter int N_CH   = 4,
    parameter int STAGES = 2,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N_CH*WIDTH-1:0]   in_a,
    input  logic [N_CH*WIDTH-1:0]   in_b,
    input  logic [2:0]              in_op,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [N_CH*WIDTH-1:0]   out_r,
    output logic [N_CH-1:0]         out_ones,
    output logic [N_CH-1:0]         out_zero,
    output logic                    out_err,
    input  logic                    clear_cnt,
    output logic [CNT_W-1:0]        txn_cnt
);

    localparam int DW = N_CH * WIDTH;

    typedef struct packed {
        logic [DW-1:0]   res;
        logic [N_CH-1:0] ones;
        logic [N_CH-1:0] zero;
        logic            err;
    } beat_t;

    beat_t             w_new;
    beat_t             w_src [STAGES];
    beat_t             r_dat [STAGES];
    logic [STAGES-1:0] r_vld;
    logic [STAGES-1:0] w_adv;
    logic [STAGES-1:0] w_in;
    logic [CNT_W-1:0]  r_cnt;
    logic              w_out_hs;

    always_comb begin
        w_new = '0;
        case (in_op)
            3'd0:    w_new.res = in_a & in_b;
            3'd1:    w_new.res = in_a | in_b;
            3'd2:    w_new.res = in_a ^ in_b;
            3'd3:    w_new.res = ~(in_a & in_b);
            3'd4:    w_new.res = ~(in_a | in_b);
            3'd5:    w_new.res = ~(in_a ^ in_b);
            3'd6:    w_new.res = in_a;
            default: w_new.err = 1'b1;
        endcase
        for (int k = 0; k < N_CH; k++) begin
            w_new.ones[k] = &w_new.res[k*WIDTH +: WIDTH];
            w_new.zero[k] = ~|w_new.res[k*WIDTH +: WIDTH];
        end
    end

    // A slot moves on if the sink takes the tail or any later slot has a hole to absorb it.
    always_comb begin
        logic v_hole_after;
        v_hole_after = 1'b0;
        w_adv        = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            w_adv[i]     = r_vld[i] && (out_ready || v_hole_after);
            v_hole_after = v_hole_after || !r_vld[i];
        end
    end

    assign in_ready = !r_vld[0] || w_adv[0];

    always_comb begin
        w_in = '0;
        for (int i = 0; i < STAGES; i++) begin
            w_src[i] = r_dat[i];
        end
        w_in[0]  = in_valid && in_ready;
        w_src[0] = w_new;
        for (int i = 1; i < STAGES; i++) begin
            w_in[i]  = w_adv[i-1];
            w_src[i] = r_dat[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld <= '0;
            for (int i = 0; i < STAGES; i++) begin
                r_dat[i] <= '0;
            end
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                if (w_in[i]) begin
                    r_vld[i] <= 1'b1;
                    r_dat[i] <= w_src[i];
                end else if (w_adv[i]) begin
                    r_vld[i] <= 1'b0;
                end
            end
        end
    end

    assign out_valid = r_vld[STAGES-1];
    assign out_r     = r_dat[STAGES-1].res;
    assign out_ones  = r_dat[STAGES-1].ones;
    assign out_zero  = r_dat[STAGES-1].zero;
    assign out_err   = r_dat[STAGES-1].err;

    assign w_out_hs = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clear_cnt) begin
            r_cnt <= '0;
        end else if (w_out_hs && (r_cnt != '1)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign txn_cnt = r_cnt;

endmodule

// File: tb/tb_logic_gate_pipe.sv
// Directed bench for logic_gate_pipe: truth table, flags, streaming, backpressure, counter, reset.
module tb_logic_gate_pipe;

    localparam int WIDTH  = 8;
    localparam int N_CH   = 4;
    localparam int STAGES = 2;
    localparam int CNT_W  = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [2:0]  in_op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_r;
    logic [3:0]  out_ones;
    logic [3:0]  out_zero;
    logic        out_err;
    logic        clear_cnt;
    logic [15:0] txn_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    logic_gate_pipe #(.WIDTH(WIDTH), .N_CH(N_CH), .STAGES(STAGES), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_r(out_r), .out_ones(out_ones), .out_zero(out_zero), .out_err(out_err),
        .clear_cnt(clear_cnt), .txn_cnt(txn_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] val(input int t);
        return 32'h0101_0101 * 32'(t + 1);
    endfunction

    task automatic test_reset();
        #2;
        n_cmp++;
        if ({out_valid, out_r, out_ones, out_zero, out_err, txn_cnt} !== 58'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got v=%b r=%h o=%b z=%b e=%b c=%h want all zero",
                     out_valid, out_r, out_ones, out_zero, out_err, txn_cnt);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_truth_table();
        // {result, ones, zero, err} for ops 0..6 on a=F0F0_FF00, b=CCCC_0F0F
        logic [40:0] exp [7] = '{
            {32'hC0C0_0F00, 4'b0000, 4'b0001, 1'b0},
            {32'hFCFC_FF0F, 4'b0010, 4'b0000, 1'b0},
            {32'h3C3C_F00F, 4'b0000, 4'b0000, 1'b0},
            {32'h3F3F_F0FF, 4'b0001, 4'b0000, 1'b0},
            {32'h0303_00F0, 4'b0000, 4'b0010, 1'b0},
            {32'hC3C3_0FF0, 4'b0000, 4'b0000, 1'b0},
            {32'hF0F0_FF00, 4'b0010, 4'b0001, 1'b0}
        };
        out_ready = 1'b1;
        for (int op = 0; op < 7; op++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_a     = 32'hF0F0_FF00;
            in_b     = 32'hCCCC_0F0F;
            in_op    = 3'(op);
            @(negedge clk);
            in_valid = 1'b0;
            for (int w = 0; w < STAGES - 1; w++) begin
                n_cmp++;
                if (out_valid !== 1'b0) begin
                    n_bad++;
                    $display("FAIL truth_early op%0d: out_valid got %b want 0", op, out_valid);
                end
                @(negedge clk);
            end
            n_cmp++;
            if ({out_valid, out_r, out_ones, out_zero, out_err} !== {1'b1, exp[op]}) begin
                n_bad++;
                $display("FAIL truth op%0d: got v=%b r=%h o=%b z=%b e=%b want v=1 {r,o,z,e}=%h",
                         op, out_valid, out_r, out_ones, out_zero, out_err, exp[op]);
            end
        end
    endtask

    task automatic test_flags();
        logic [40:0] exp [2] = '{
            {32'hFF00_FF00, 4'b1010, 4'b0101, 1'b0},
            {32'h0000_0000, 4'b0000, 4'b1111, 1'b1}
        };
        logic [2:0] ops [2] = '{3'd0, 3'd7};
        for (int j = 0; j < 2; j++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_a     = 32'hFF00_FF00;
            in_b     = 32'hFF00_FF00;
            in_op    = ops[j];
            @(negedge clk);
            in_valid = 1'b0;
            repeat (STAGES - 1) @(negedge clk);
            n_cmp++;
            if ({out_valid, out_r, out_ones, out_zero, out_err} !== {1'b1, exp[j]}) begin
                n_bad++;
                $display("FAIL flags op%0d: got v=%b r=%h o=%b z=%b e=%b want v=1 {r,o,z,e}=%h",
                         ops[j], out_valid, out_r, out_ones, out_zero, out_err, exp[j]);
            end
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        clear_cnt = 1'b1;
        @(negedge clk);
        clear_cnt = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 16 + STAGES + 1; k++) begin
            if (k > 0) @(negedge clk);
            if (k < 16) begin
                n_cmp++;
                if (in_ready !== 1'b1) begin
                    n_bad++;
                    $display("FAIL stream_ready k=%0d: got %b want 1", k, in_ready);
                end
            end
            if (k >= STAGES && k < 16 + STAGES) begin
                n_cmp++;
                if ({out_valid, out_r} !== {1'b1, val(k - STAGES)}) begin
                    n_bad++;
                    $display("FAIL stream_out k=%0d: got v=%b r=%h want v=1 r=%h",
                             k, out_valid, out_r, val(k - STAGES));
                end
            end else begin
                n_cmp++;
                if (out_valid !== 1'b0) begin
                    n_bad++;
                    $display("FAIL stream_idle k=%0d: out_valid got %b want 0", k, out_valid);
                end
            end
            in_valid = (k < 16);
            in_a     = val(k);
            in_b     = '0;
            in_op    = 3'd6;
        end
        in_valid = 1'b0;
        n_cmp++;
        if (txn_cnt !== 16'd16) begin
            n_bad++;
            $display("FAIL stream_count: got %0d want 16", txn_cnt);
        end
    endtask

    task automatic test_backpressure();
        int  tx  = 0;
        int  rx  = 0;
        logic acc = 1'b0;
        logic ohs = 1'b0;
        out_ready = 1'b0;
        for (int c = 0; c < 60 && rx < 6; c++) begin
            @(negedge clk);
            if (acc) tx++;
            if (ohs) rx++;
            if (c == 10) begin
                n_cmp++;
                if (tx != STAGES || in_ready !== 1'b0) begin
                    n_bad++;
                    $display("FAIL bp_fill: accepted %0d in_ready %b want %0d and 0", tx, in_ready, STAGES);
                end
            end
            if (out_valid && rx < 6) begin
                n_cmp++;
                if (out_r !== val(rx + 32)) begin
                    n_bad++;
                    $display("FAIL bp_data c=%0d: got %h want %h", c, out_r, val(rx + 32));
                end
            end
            out_ready = (c >= 10);
            in_valid  = (tx < 6);
            in_a      = val(tx + 32);
            in_b      = '0;
            in_op     = 3'd6;
            #1;
            acc = in_valid && in_ready;
            ohs = out_valid && out_ready;
        end
        in_valid = 1'b0;
        n_cmp++;
        if (rx != 6 || tx != 6) begin
            n_bad++;
            $display("FAIL bp_drain: sent %0d received %0d want 6 and 6", tx, rx);
        end
    endtask

    task automatic test_counter();
        @(negedge clk);
        clear_cnt = 1'b1;
        @(negedge clk);
        clear_cnt = 1'b0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_a      = 32'h1234_5678;
        in_b      = 32'hFFFF_FFFF;
        in_op     = 3'd0;
        repeat (65539) @(negedge clk);
        in_valid = 1'b0;
        repeat (STAGES + 2) @(negedge clk);
        n_cmp++;
        if (txn_cnt !== 16'hFFFF) begin
            n_bad++;
            $display("FAIL cnt_saturate: got %h want ffff", txn_cnt);
        end
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (STAGES - 1) @(negedge clk);
        n_cmp++;
        if ({out_valid, txn_cnt} !== {1'b1, 16'hFFFF}) begin
            n_bad++;
            $display("FAIL cnt_pre_clear: got v=%b c=%h want v=1 c=ffff", out_valid, txn_cnt);
        end
        clear_cnt = 1'b1;
        @(negedge clk);
        clear_cnt = 1'b0;
        n_cmp++;
        if ({out_valid, txn_cnt} !== {1'b0, 16'h0000}) begin
            n_bad++;
            $display("FAIL cnt_clear_wins: got v=%b c=%h want v=0 c=0000", out_valid, txn_cnt);
        end
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (STAGES) @(negedge clk);
        n_cmp++;
        if (txn_cnt !== 16'd1) begin
            n_bad++;
            $display("FAIL cnt_after_clear: got %h want 0001", txn_cnt);
        end
    endtask

    task automatic test_reset_midflight();
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b1;
        in_a     = val(50);
        in_op    = 3'd6;
        @(negedge clk);
        in_a = val(51);
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++;
        if ({out_valid, out_r} !== {1'b1, val(50)}) begin
            n_bad++;
            $display("FAIL mid_pre: got v=%b r=%h want v=1 r=%h", out_valid, out_r, val(50));
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({out_valid, out_r, out_ones, out_zero, out_err, txn_cnt} !== 58'd0) begin
            n_bad++;
            $display("FAIL mid_reset: got v=%b r=%h o=%b z=%b e=%b c=%h want all zero",
                     out_valid, out_r, out_ones, out_zero, out_err, txn_cnt);
        end
        #4 rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_no_partial: out_valid got %b want 0", out_valid);
        end
        in_valid = 1'b1;
        in_a     = val(52);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (STAGES - 1) begin
            n_cmp++;
            if (out_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL mid_latency_early: out_valid got %b want 0", out_valid);
            end
            @(negedge clk);
        end
        n_cmp++;
        if ({out_valid, out_r} !== {1'b1, val(52)}) begin
            n_bad++;
            $display("FAIL mid_first_beat: got v=%b r=%h want v=1 r=%h", out_valid, out_r, val(52));
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_op     = '0;
        out_ready = 1'b1;
        clear_cnt = 1'b0;
        test_reset();
        test_truth_table();
        test_flags();
        test_back_to_back();
        test_backpressure();
        test_counter();
        test_reset_midflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
